phase_serial_tx: RTL and testbench
==================================

PHASE_SERIAL_TX -- requirements
Module: phase_serial_tx

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame, legal range 1..16.
REQ-002 Parameter HOLD, default 2: clock cycles per line symbol, legal range 1..15.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  DATA_W  payload word, sampled at acceptance only.
REQ-006 valid  input  1  producer offers data_in this cycle.
REQ-007 ready  output  1  block accepts a word this cycle; registered.
REQ-008 A  output  1  serial line driven to the downstream phase-sampled detector; registered.
REQ-009 strobe  output  1  high on the final cycle of each symbol, marking the receiver sample point; registered.
REQ-010 busy  output  1  frame in progress; registered.
REQ-011 done  output  1  one-cycle pulse at frame completion; registered.

Function
REQ-012 The states SHALL be IDLE, START, DATA and STOP.
REQ-013 A transfer SHALL occur on a rising edge with valid=1 and ready=1; data_in SHALL be latched into a shift register, and IDLE SHALL go to START.
REQ-014 ready SHALL be 1 only in IDLE; valid while ready=0 SHALL be ignored with no queuing.
REQ-015 Changes to data_in after acceptance SHALL NOT affect the frame in flight.
REQ-016 Line levels: IDLE A=0; START A=1 for HOLD cycles; DATA one symbol per bit, LSB first, each held HOLD cycles; STOP A=0 for HOLD cycles.
REQ-017 A SHALL change only at symbol boundaries, and the first START cycle SHALL be the cycle after the accepting edge.
REQ-018 A frame SHALL last exactly (DATA_W+2)*HOLD cycles from the first START cycle to the last STOP cycle.
REQ-019 strobe SHALL be 1 on the cycle where the hold counter equals HOLD-1 in START, DATA and STOP, and 0 in IDLE; with HOLD=1, strobe SHALL be 1 on every frame cycle.
REQ-020 The hold counter SHALL be $clog2(HOLD+1) bits wide, reload to 0 at each symbol boundary, and never exceed HOLD-1.
REQ-021 The bit index SHALL count 0..DATA_W-1; after index DATA_W-1 with the counter at HOLD-1, DATA SHALL go to STOP.
REQ-022 After the last STOP cycle the block SHALL enter IDLE, with done=1 and ready=1 in that same first IDLE cycle; busy SHALL be 1 in START, DATA and STOP only.
REQ-023 Back-to-back: a transfer on the done cycle SHALL start the next frame's START on the following cycle, with no extra idle gap.
REQ-024 A payload of all zeros SHALL still produce the START symbol, so a frame is always distinguishable from idle.

Reset
REQ-025 While reset=1: state=IDLE, A=0, strobe=0, busy=0, done=0, ready=0, and hold counter, bit index and shift register cleared.
REQ-026 ready SHALL rise on the first rising edge after reset deasserts.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, asynchronously driving A=0, with no done pulse.

Structure
REQ-028 Package phase_serial_pkg SHALL hold the state enum (IDLE, START, DATA, STOP) and the default DATA_W and HOLD constants.
REQ-029 Sub-module symbol_timer SHALL implement the HOLD counter with inputs load and en and output last (count == HOLD-1); all other logic SHALL stay in phase_serial_tx.

Verification
REQ-030 DATA_W=8, HOLD=2, send 0xA5 -> A sequence 1,1 then 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1 then 0,0; 10 strobes; done=1 at cycle 21 after acceptance.
REQ-031 Two words 0x01 then 0xFF, valid held continuously -> second START begins the cycle after the done cycle; the two frames total 40 cycles.
REQ-032 Assert valid with 0x3C during busy -> no effect; frame 0x5A completes unchanged and ready stays 0 until done.
REQ-033 Assert reset at cycle 7 of a frame -> A=0 within the same cycle without waiting for a clock; no done; ready=1 one edge after release.
REQ-034 HOLD=1, DATA_W=4, send 0x0 -> A=1,0,0,0,0,0; strobe high for all 6 cycles; done on cycle 7.
REQ-035 Scoreboard check on every run -> A is stable within each symbol and changes only on the cycle after strobe=1.

Source files
------------

// File: rtl/phase_serial_pkg.sv
// Shared types and defaults for the phase-sampled serial transmitter.
package phase_serial_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_HOLD   = 2;
endpackage

// File: rtl/phase_serial_symbol_timer.sv
// Per-symbol hold counter: counts 0..HOLD-1 and flags the last cycle of a symbol.
module symbol_timer #(
  parameter int HOLD = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic last,
  output logic last_next
);
  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] LAST_V = CW'(HOLD - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)     r_cnt <= '0;
    else if (load) r_cnt <= '0;
    else if (en)   r_cnt <= r_cnt + CW'(1);
  end

  assign last = (r_cnt == LAST_V);
  // Lookahead of last for the registered strobe output.
  assign last_next = load ? (HOLD == 1) : ((r_cnt + CW'(1)) == LAST_V);
endmodule

// File: rtl/phase_serial_tx.sv
// Frame transmitter: START(1), DATA_W bits LSB first, STOP(0), each held HOLD cycles.
module phase_serial_tx
  import phase_serial_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int HOLD   = DEF_HOLD
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              A,
  output logic              strobe,
  output logic              busy,
  output logic              done
);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_sh, w_sh_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic              r_ready, r_A, r_strobe, r_busy, r_done;
  logic              w_ready_nxt, w_A_nxt, w_strobe_nxt, w_busy_nxt, w_done_nxt;
  logic              w_accept, w_last, w_last_nxt, w_load, w_en;

  assign w_accept = (r_state == IDLE) && r_ready && valid;
  assign w_en     = (r_state != IDLE);
  assign w_load   = (r_state == IDLE) || w_last;

  symbol_timer #(.HOLD(HOLD)) u_timer (
    .CLK       (CLK),
    .reset     (reset),
    .load      (w_load),
    .en        (w_en),
    .last      (w_last),
    .last_next (w_last_nxt)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = START;
      START:   if (w_last) w_state_nxt = DATA;
      DATA:    if (w_last && (r_idx == IDX_LAST)) w_state_nxt = STOP;
      STOP:    if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sh_nxt  = r_sh;
    w_idx_nxt = r_idx;
    if (w_accept) begin
      w_sh_nxt  = data_in;
      w_idx_nxt = '0;
    end else if ((r_state == DATA) && w_last) begin
      w_sh_nxt  = r_sh >> 1;
      w_idx_nxt = r_idx + IW'(1);
    end
  end

  // Outputs are computed for the next cycle so they can be registered.
  always_comb begin
    w_ready_nxt  = (w_state_nxt == IDLE);
    w_busy_nxt   = (w_state_nxt != IDLE);
    w_done_nxt   = (r_state == STOP) && w_last;
    w_strobe_nxt = w_busy_nxt && w_last_nxt;
    case (w_state_nxt)
      START:   w_A_nxt = 1'b1;
      DATA:    w_A_nxt = w_sh_nxt[0];
      default: w_A_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_sh     <= '0;
      r_idx    <= '0;
      r_ready  <= 1'b0;
      r_A      <= 1'b0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_sh     <= w_sh_nxt;
      r_idx    <= w_idx_nxt;
      r_ready  <= w_ready_nxt;
      r_A      <= w_A_nxt;
      r_strobe <= w_strobe_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign ready  = r_ready;
  assign A      = r_A;
  assign strobe = r_strobe;
  assign busy   = r_busy;
  assign done   = r_done;
endmodule

// File: tb/tb_phase_serial_tx.sv
// Directed bench for phase_serial_tx: 8-bit/HOLD=2 and 4-bit/HOLD=1 instances.
module tb_phase_serial_tx;
  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din_a = '0;
  logic       valid_a = 1'b0;
  logic       ready_a, A_a, strobe_a, busy_a, done_a;
  logic [3:0] din_b = '0;
  logic       valid_b = 1'b0;
  logic       ready_b, A_b, strobe_b, busy_b, done_b;

  int nasrt = 0;
  int nfail = 0;
  logic pA_a = 1'b0, pS_a = 1'b0, pB_a = 1'b0;
  logic pA_b = 1'b0, pS_b = 1'b0, pB_b = 1'b0;

  always #5 CLK = ~CLK;

  phase_serial_tx #(.DATA_W(8), .HOLD(2)) dut_a (
    .CLK(CLK), .reset(reset), .data_in(din_a), .valid(valid_a),
    .ready(ready_a), .A(A_a), .strobe(strobe_a), .busy(busy_a), .done(done_a));

  phase_serial_tx #(.DATA_W(4), .HOLD(1)) dut_b (
    .CLK(CLK), .reset(reset), .data_in(din_b), .valid(valid_b),
    .ready(ready_b), .A(A_b), .strobe(strobe_b), .busy(busy_b), .done(done_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, and check A only moves after a strobe.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (!reset && pB_a) chk("a_stable", {31'b0, (A_a !== pA_a) && !pS_a}, 0);
    if (!reset && pB_b) chk("b_stable", {31'b0, (A_b !== pA_b) && !pS_b}, 0);
    pA_a = A_a; pS_a = strobe_a; pB_a = busy_a;
    pA_b = A_b; pS_b = strobe_b; pB_b = busy_b;
  endtask

  // Called on the first START cycle; returns on the done cycle.
  task automatic run_a(input string tag, input logic [19:0] pat, input int inj);
    int ns;
    ns = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == inj) begin
        valid_a = 1'b1;
        din_a   = 8'h3C;
      end
      chk($sformatf("%s_A%0d", tag, i), {31'b0, A_a}, {31'b0, pat[19-i]});
      chk($sformatf("%s_busy%0d", tag, i), {31'b0, busy_a}, 1);
      chk($sformatf("%s_rdy%0d", tag, i), {31'b0, ready_a}, 0);
      chk($sformatf("%s_done%0d", tag, i), {31'b0, done_a}, 0);
      chk($sformatf("%s_stb%0d", tag, i), {31'b0, strobe_a}, (i % 2 == 1) ? 1 : 0);
      if (strobe_a) ns++;
      tick();
    end
    chk({tag, "_nstb"}, ns, 10);
    chk({tag, "_done"}, {31'b0, done_a}, 1);
    chk({tag, "_rdy_done"}, {31'b0, ready_a}, 1);
    chk({tag, "_busy_done"}, {31'b0, busy_a}, 0);
    chk({tag, "_A_done"}, {31'b0, A_a}, 0);
  endtask

  initial begin
    logic [19:0] pat_a5, pat_01, pat_ff, pat_5a;
    logic [5:0]  pat_b0;
    pat_a5 = 20'b11110011000011001100;
    pat_01 = 20'b11110000000000000000;
    pat_ff = 20'b11111111111111111100;
    pat_5a = 20'b11001100111100110000;
    pat_b0 = 6'b100000;

    #12;
    chk("rst_ready", {31'b0, ready_a}, 0);
    chk("rst_A", {31'b0, A_a}, 0);
    chk("rst_busy", {31'b0, busy_a}, 0);
    chk("rst_done", {31'b0, done_a}, 0);
    chk("rst_strobe", {31'b0, strobe_a}, 0);
    chk("rst_ready_b", {31'b0, ready_b}, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_ready", {31'b0, ready_a}, 1);
    chk("post_rst_ready_b", {31'b0, ready_b}, 1);
    chk("post_rst_busy", {31'b0, busy_a}, 0);

    // 0xA5, data_in scrambled after acceptance
    din_a = 8'hA5; valid_a = 1'b1;
    tick();
    valid_a = 1'b0; din_a = 8'h00;
    run_a("a5", pat_a5, -1);
    tick();
    chk("a5_done_pulse", {31'b0, done_a}, 0);
    chk("a5_idle_ready", {31'b0, ready_a}, 1);

    // back-to-back 0x01 then 0xFF with valid held
    din_a = 8'h01; valid_a = 1'b1;
    tick();
    din_a = 8'hFF;
    run_a("w01", pat_01, -1);
    tick();
    valid_a = 1'b0;
    run_a("wff", pat_ff, -1);
    tick();
    chk("wff_idle_busy", {31'b0, busy_a}, 0);

    // 0x5A with a 0x3C offer injected mid-frame
    din_a = 8'h5A; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    run_a("w5a", pat_5a, 4);
    valid_a = 1'b0;
    tick();
    chk("w5a_no_queue", {31'b0, busy_a}, 0);

    // reset at cycle 7 of a frame
    din_a = 8'hFF; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int i = 1; i < 7; i++) tick();
    chk("abort_A_before", {31'b0, A_a}, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_A_async", {31'b0, A_a}, 0);
    chk("abort_busy", {31'b0, busy_a}, 0);
    chk("abort_ready", {31'b0, ready_a}, 0);
    chk("abort_strobe", {31'b0, strobe_a}, 0);
    tick();
    tick();
    chk("abort_no_done", {31'b0, done_a}, 0);
    reset = 1'b0;
    tick();
    chk("abort_ready_rel", {31'b0, ready_a}, 1);
    chk("abort_done_rel", {31'b0, done_a}, 0);
    chk("abort_busy_rel", {31'b0, busy_a}, 0);

    // HOLD=1, DATA_W=4, all-zero payload
    din_b = 4'h0; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("b_A%0d", i), {31'b0, A_b}, {31'b0, pat_b0[5-i]});
      chk($sformatf("b_stb%0d", i), {31'b0, strobe_b}, 1);
      chk($sformatf("b_busy%0d", i), {31'b0, busy_b}, 1);
      chk($sformatf("b_done%0d", i), {31'b0, done_b}, 0);
      tick();
    end
    chk("b_done", {31'b0, done_b}, 1);
    chk("b_A_idle", {31'b0, A_b}, 0);
    chk("b_stb_idle", {31'b0, strobe_b}, 0);
    chk("b_ready_idle", {31'b0, ready_b}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end
endmodule
